// File: rtl/serial_seq_pkg.sv
// -----------------------------------------------------------------------------
// serial_seq_pkg
// Shared definitions for the serial pattern transmitter and its pair counter:
// default widths and the 2-bit transmitter state encoding.
// -----------------------------------------------------------------------------
package serial_seq_pkg;

  localparam int DEF_WIDTH  = 8;  // pattern length in bits
  localparam int DEF_CNT_W  = 4;  // repeat count width
  localparam int DEF_PAIR_W = 8;  // saturating "11" pair counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pair_counter.sv
// -----------------------------------------------------------------------------
// seq_pair_counter
// Counts 1-after-1 adjacencies in a stream of valid bits. Holds the previous
// valid bit and a saturating counter. Also usable as a detector scoreboard.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   i_clear     start a new count; with i_valid the bit seeds the prev register
//   i_valid     i_bit is a real stream bit on this edge
//   i_bit       stream bit
//   o_pair_cnt  number of 1-after-1 pairs since the last clear (saturating)
// -----------------------------------------------------------------------------
module seq_pair_counter #(
  parameter int PAIR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic              i_bit,
  output logic [PAIR_W-1:0] o_pair_cnt
);

  logic              r_prev;
  logic [PAIR_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      // The first bit of a new stream cannot complete a pair.
      r_cnt  <= '0;
      r_prev <= i_valid & i_bit;
    end else if (i_valid) begin
      r_prev <= i_bit;
      if (r_prev && i_bit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + PAIR_W'(1);
      end
    end
  end

  assign o_pair_cnt = r_cnt;

endmodule

// File: rtl/serial_seq_tx.sv
// -----------------------------------------------------------------------------
// serial_seq_tx
// Loads a WIDTH-bit pattern, shifts it out MSB-first one bit per clock, and
// repeats it repeat_cnt extra times with a single guard zero between repeats.
// Counts emitted "11" adjacencies for cross-checking a sequence detector.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load           transaction request, accepted only while in_ready=1
//   pattern        bits to send (MSB first), sampled on accept
//   repeat_cnt     extra repetitions, sampled on accept
//   in_ready       high only in IDLE
//   serial_out     registered serial bit
//   bit_valid      serial_out carries a pattern or guard bit
//   busy           high in SHIFT or GAP
//   done           one-cycle pulse after the final bit
//   pair_cnt       1-after-1 pairs in the current/last transaction
// -----------------------------------------------------------------------------
module serial_seq_tx
  import serial_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PAIR_W = DEF_PAIR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [CNT_W-1:0]  repeat_cnt,
  output logic              in_ready,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic [PAIR_W-1:0] pair_cnt
);

  localparam int BC_W = $clog2(WIDTH + 1);

  state_t            r_state,  w_state_nxt;
  logic [WIDTH-1:0]  r_pattern, w_pattern_nxt;
  logic [WIDTH-1:0]  r_shreg,  w_shreg_nxt;
  logic [BC_W-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic [CNT_W-1:0]  r_reps,   w_reps_nxt;
  logic              r_serial, w_serial_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_done,   w_done_nxt;
  logic              w_accept;

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_shreg_nxt   = r_shreg;
    w_bitcnt_nxt  = r_bitcnt;
    w_reps_nxt    = r_reps;
    w_serial_nxt  = 1'b0;
    w_valid_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_accept      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (load) begin
          w_accept      = 1'b1;
          w_pattern_nxt = pattern;
          w_reps_nxt    = repeat_cnt;
          w_serial_nxt  = pattern[WIDTH-1];
          w_valid_nxt   = 1'b1;
          w_shreg_nxt   = pattern << 1;
          w_bitcnt_nxt  = BC_W'(1);
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (r_bitcnt < BC_W'(WIDTH)) begin
          w_serial_nxt = r_shreg[WIDTH-1];
          w_valid_nxt  = 1'b1;
          w_shreg_nxt  = r_shreg << 1;
          w_bitcnt_nxt = r_bitcnt + BC_W'(1);
        end else if (r_reps != '0) begin
          // Guard zero: a valid bit, so it breaks pairs across repeats.
          w_valid_nxt = 1'b1;
          w_reps_nxt  = r_reps - CNT_W'(1);
          w_state_nxt = GAP;
        end else begin
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      GAP: begin
        w_serial_nxt = r_pattern[WIDTH-1];
        w_valid_nxt  = 1'b1;
        w_shreg_nxt  = r_pattern << 1;
        w_bitcnt_nxt = BC_W'(1);
        w_state_nxt  = SHIFT;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The captured pattern is reset along with the rest of the datapath, so
  // no register carries an X into a GAP reload after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_reps    <= '0;
      r_serial  <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pattern <= w_pattern_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_reps    <= w_reps_nxt;
      r_serial  <= w_serial_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Fed with the same next-cycle values as serial_out/bit_valid, so the count
  // tracks exactly the bits that appear on the line.
  seq_pair_counter #(
    .PAIR_W (PAIR_W)
  ) u_pair_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_accept),
    .i_valid    (w_valid_nxt),
    .i_bit      (w_serial_nxt),
    .o_pair_cnt (pair_cnt)
  );

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state == SHIFT) || (r_state == GAP);
  assign serial_out = r_serial;
  assign bit_valid  = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_serial_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_seq_tx
// Directed bench for serial_seq_tx. Expected bits are queued when a
// transaction is launched and popped as bit_valid cycles appear.
// -----------------------------------------------------------------------------
module tb_serial_seq_tx;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 4;
  localparam int PAIR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              load;
  logic [WIDTH-1:0]  pattern;
  logic [CNT_W-1:0]  repeat_cnt;
  logic              in_ready;
  logic              serial_out;
  logic              bit_valid;
  logic              busy;
  logic              done;
  logic [PAIR_W-1:0] pair_cnt;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  serial_seq_tx #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .PAIR_W (PAIR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .pair_cnt   (pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the bit stream a transaction must produce and drive the request.
  task automatic launch(input logic [WIDTH-1:0] p, input int reps);
    for (int r = 0; r <= reps; r++) begin
      if (r > 0) exp_q.push_back(1'b0);
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(p[i]);
    end
    load       = 1'b1;
    pattern    = p;
    repeat_cnt = CNT_W'(reps);
  endtask

  // Follow one transaction from its first bit to the IDLE cycle after done.
  // inject_at > 0 raises load with a different pattern mid-transaction.
  task automatic follow(input int reps, input int exp_pairs, input bit hold_load,
                        input int inject_at);
    int exp_bits = (reps + 1) * WIDTH + reps;
    int cyc      = 0;
    int nvalid   = 0;
    bit got_done = 1'b0;
    while (!got_done && cyc < exp_bits + 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("first_bit_valid", bit_valid, 1);
        check("busy_while_shift", busy, 1);
        check("not_ready_while_busy", in_ready, 0);
        if (!hold_load) load = 1'b0;
      end
      if (inject_at > 0 && cyc == inject_at) begin
        load       = 1'b1;
        pattern    = 8'hAA;
        repeat_cnt = 4'd3;
      end
      if (inject_at > 0 && cyc == inject_at + 3) load = 1'b0;
      if (bit_valid) begin
        nvalid++;
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else check("serial_bit", serial_out, exp_q.pop_front());
      end
      if (done) got_done = 1'b1;
    end
    check("done_seen", got_done, 1);
    check("done_cycle", cyc, exp_bits + 1);
    check("valid_count", nvalid, exp_bits);
    check("queue_drained", exp_q.size(), 0);
    check("pair_cnt", pair_cnt, exp_pairs);
    @(negedge clk);
    check("ready_after_done", in_ready, 1);
    check("done_one_cycle", done, 0);
    check("idle_not_valid", bit_valid, 0);
    check("pair_cnt_held", pair_cnt, exp_pairs);
  endtask

  initial begin
    reset_n    = 1'b0;
    load       = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_in_ready", in_ready, 1);
    check("rst_serial_out", serial_out, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pair_cnt", pair_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single transmission
    launch(8'b1011_0110, 0);
    follow(0, 2, 1'b0, 0);

    // Repeat with guard zero between two all-ones patterns
    launch(8'hFF, 1);
    follow(1, 14, 1'b0, 0);

    // All-zero pattern, three transmissions
    launch(8'h00, 2);
    follow(2, 0, 1'b0, 0);

    // Load while busy must be ignored
    launch(8'h0F, 0);
    follow(0, 3, 1'b0, 3);

    // Mid-operation reset during bit 4 of 8'hFF
    launch(8'hFF, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) load = 1'b0;
      if (bit_valid) check("pre_reset_bit", serial_out, exp_q.pop_front());
      else check("pre_reset_valid", bit_valid, 1);
    end
    #2 reset_n = 1'b0;
    #1;
    check("abort_serial_out", serial_out, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_pair_cnt", pair_cnt, 0);
    check("abort_bit_valid", bit_valid, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    launch(8'b0110_1100, 0);
    follow(0, 2, 1'b0, 0);

    // Back-to-back with load held high: DONE and IDLE are the only gap cycles
    launch(8'hC3, 0);
    follow(0, 2, 1'b1, 0);
    launch(8'hC3, 0);
    follow(0, 2, 1'b1, 0);
    load = 1'b0;
    @(negedge clk);
    check("stays_idle", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_seq_tx.md
Name: serial_seq_tx

Overview:
- Serial pattern transmitter that drives the single-bit `in` line of the team's sequence-detector FSMs (for example, the "11" Mealy detector).
- Loads a WIDTH-bit pattern, shifts it out MSB-first one bit per clock, and repeats it a programmable number of times with a guard zero between repeats.
- Keeps its own count of emitted "11" adjacencies, so a bench or top level can cross-check a detector's hit count against it.

Parameters:
- WIDTH, 8: pattern length in bits (≥2).
- CNT_W, 4: width of repeat_cnt.
- PAIR_W, 8: width of pair_cnt (saturating).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  request; accepted only when in_ready=1.
- pattern  input  WIDTH  bits to send, MSB first; sampled on accept.
- repeat_cnt  input  CNT_W  extra repetitions; total transmissions = repeat_cnt+1; sampled on accept.
- in_ready  output  1  high only in IDLE.
- serial_out  output  1  registered serial bit, feeds a detector's `in`.
- bit_valid  output  1  high on every cycle serial_out carries a pattern or guard bit.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-cycle pulse after the final bit.
- pair_cnt  output  PAIR_W  number of emitted valid 1-after-1 pairs in the current/last transaction.

Behaviour:
- Reset values (async, on reset_n=0):
  - state=IDLE, in_ready=1.
  - serial_out, bit_valid, busy, done = 0.
  - pair_cnt=0; shift reg, bit counter, repeat counter, prev-bit = 0.
- Reset asserted mid-transaction aborts immediately with no done pulse.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - in_ready=1, serial_out=0, bit_valid=0.
  - On an edge with load=1:
    - capture pattern and repeat_cnt;
    - serial_out<=pattern[WIDTH-1], bit_valid<=1;
    - shreg<=pattern<<1, bitcnt<=1;
    - pair_cnt<=0, prev<=pattern[WIDTH-1];
    - go to SHIFT.
  - Latency: first bit is visible in the cycle after the accepting edge.
- SHIFT, while bitcnt<WIDTH: each edge emits shreg MSB, shifts left, and increments bitcnt.
- SHIFT, when bitcnt==WIDTH:
  - If reps_left>0: go to GAP; serial_out<=0, bit_valid<=1; decrement reps_left.
  - Otherwise: go to DONE; serial_out<=0, bit_valid<=0, done<=1.
- GAP (exactly one cycle, the guard zero):
  - next edge reloads shreg from the captured pattern;
  - emits captured MSB, bitcnt<=1, go to SHIFT.
- DONE: done=1 for one cycle; next edge goes to IDLE, so in_ready rises one cycle after done.
- busy = (state==SHIFT || state==GAP); in_ready = (state==IDLE).
- load outside IDLE is ignored (no capture, no effect). load held high in IDLE restarts immediately.
- Pair counting:
  - on each edge that emits a valid bit b, increment pair_cnt if prev==1 && b==1, then prev<=b;
  - the guard zero is a valid bit and breaks pairs across repeats;
  - pair_cnt saturates at 2^PAIR_W-1 and holds its value after DONE until the next accept.
- Bit cycles per transaction: (repeat_cnt+1)·WIDTH + repeat_cnt.

Decomposition:
- Package serial_seq_pkg holds:
  - state localparams IDLE=0, SHIFT=1, GAP=2, DONE=3 (2-bit state);
  - default widths.
- One sub-module, seq_pair_counter (prev-bit register plus saturating PAIR_W counter, with clear and valid inputs). The same counter is reusable as a detector scoreboard.

Test Plan:
- Single transmission: pattern=8'b1011_0110, repeat_cnt=0, load for 1 cycle.
  -> serial_out=1,0,1,1,0,1,1,0 on 8 consecutive bit_valid cycles.
  -> done pulses on the 9th cycle; pair_cnt=2; in_ready=1 on the 10th cycle.
- Repeat with guard zero: pattern=8'hFF, repeat_cnt=1.
  -> 8 ones, 1 guard zero, 8 ones (17 bit_valid cycles).
  -> pair_cnt=14; a connected "11" detector sees no pair across the gap.
- All-zero pattern: pattern=8'h00, repeat_cnt=2.
  -> 26 bit_valid cycles, all serial_out=0; pair_cnt=0; one done pulse.
- Load while busy: load=1 with pattern=8'hAA during SHIFT of 8'h0F.
  -> output continues 0,0,0,0,1,1,1,1; pair_cnt=3; the 8'hAA load is not captured.
- Mid-operation reset: reset_n=0 during bit 4 of 8'hFF.
  -> outputs go to reset values immediately (serial_out=0, busy=0, in_ready=1, pair_cnt=0) with no done.
  -> a fresh load after release transmits normally.
- Back-to-back: load held high continuously.
  -> a new transaction starts on the IDLE cycle after each done.
  -> consecutive transmissions are separated by exactly two non-valid cycles (DONE, IDLE).
